// File: rtl/parity_pkg.sv
// parity_pkg: parity mode constants and FSM state encoding shared by the checker
package parity_pkg;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
  typedef enum logic {ST_IDLE = 1'b0, ST_ACC = 1'b1} state_t;
endpackage

// File: rtl/parity_word.sv
// parity_word: reduction parity of one data word and its check against the received parity bit
module parity_word #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic              par,
  input  logic              mode,
  output logic              red,
  output logic              chk_err
);
  assign red     = ^data;
  assign chk_err = (red ^ par) != mode;
endmodule

// File: rtl/parity_stream_checker.sv
// parity_stream_checker: per-beat parity check, per-frame parity generation, saturating error count
module parity_stream_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              odd_sel,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_par,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_par,
  output logic              m_err,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  err_cnt
);
  state_t state_q;
  logic   acc_q, err_acc_q, mode_q;
  logic   idle, mode, accept, red, w_err, acc_d, err_acc_d;
  assign idle      = state_q == ST_IDLE;
  assign mode      = idle ? odd_sel : mode_q;
  assign s_ready   = ~m_valid | m_ready;
  assign accept    = s_valid & s_ready;
  assign acc_d     = idle ? red : acc_q ^ red;
  assign err_acc_d = idle ? w_err : err_acc_q | w_err;
  parity_word #(.DATA_W(DATA_W)) u_word (
    .data    (s_data),
    .par     (s_par),
    .mode    (mode),
    .red     (red),
    .chk_err (w_err)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= 1'b0;
      err_acc_q <= 1'b0;
      mode_q    <= 1'b0;
      m_valid   <= 1'b0;
      m_par     <= 1'b0;
      m_err     <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (accept) begin
        if (idle) mode_q <= odd_sel;
        acc_q     <= acc_d;
        err_acc_q <= err_acc_d;
        state_q   <= s_last ? ST_IDLE : ST_ACC;
      end
      if (accept && s_last) begin
        m_valid <= 1'b1;
        m_par   <= acc_d ^ mode;
        m_err   <= err_acc_d;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      if (clr_cnt) err_cnt <= '0;
      else if (accept && w_err && !(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_parity_stream_checker.sv
// tb_parity_stream_checker: directed table plus hand-written frame sequences for both counter widths
module tb_parity_stream_checker;
  logic       clk = 1'b0, rst_n = 1'b0, odd_sel = 1'b0, s_valid = 1'b0, s_par = 1'b0, s_last = 1'b0;
  logic       m_ready = 1'b1, clr_cnt = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready, m_valid, m_par, m_err;
  logic       s_ready2, m_valid2, m_par2, m_err2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  int         checks = 0, failures = 0;
  typedef struct {
    logic       odd;
    logic [7:0] data;
    logic       par;
    logic       exp_par;
    logic       exp_err;
    int         exp_cnt;
  } vec_t;
  vec_t vecs[8];
  always #5 clk = ~clk;
  parity_stream_checker #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .odd_sel(odd_sel), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_par(s_par), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_par(m_par), .m_err(m_err), .clr_cnt(clr_cnt), .err_cnt(err_cnt)
  );
  parity_stream_checker #(.DATA_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .odd_sel(odd_sel), .s_valid(s_valid), .s_ready(s_ready2),
    .s_data(s_data), .s_par(s_par), .s_last(s_last), .m_valid(m_valid2), .m_ready(m_ready),
    .m_par(m_par2), .m_err(m_err2), .clr_cnt(clr_cnt), .err_cnt(err_cnt2)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic send(input logic odd, input logic [7:0] data, input logic par, input logic last);
    odd_sel = odd; s_data = data; s_par = par; s_last = last; s_valid = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    s_valid = 1'b0; s_last = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string name, input logic v, input logic p, input logic e);
    chk({name, ".m_valid"}, m_valid, v);
    chk({name, ".m_par"}, m_par, p);
    chk({name, ".m_err"}, m_err, e);
  endtask
  task automatic do_reset();
    s_valid = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
  endtask
  initial begin
    vecs[0] = '{1'b1, 8'h0F, 1'b1, 1'b1, 1'b0, 0};
    vecs[1] = '{1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 0};
    vecs[2] = '{1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 0};
    vecs[3] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 0};
    vecs[4] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1};
    vecs[5] = '{1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 2};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2};
    vecs[7] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 2};
    // reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.err_cnt", err_cnt, 0);
    chk("reset.s_ready", s_ready, 1);
    // reset mid-frame drops the partial frame (bad word, acc=1)
    rst_n = 1'b1;
    send(1'b0, 8'h01, 1'b0, 1'b0);
    chk("midrst.pre_cnt", err_cnt, 1);
    s_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst.err_cnt", err_cnt, 0);
    chk("midrst.m_valid", m_valid, 0);
    send(1'b0, 8'h00, 1'b0, 1'b1);
    chk_out("midrst.frame", 1'b1, 1'b0, 1'b0);
    idle(1);
    do_reset();
    // back-to-back single-beat frames at full rate
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].odd, vecs[i].data, vecs[i].par, 1'b1);
      chk_out($sformatf("vec%0d", i), 1'b1, vecs[i].exp_par, vecs[i].exp_err);
      chk($sformatf("vec%0d.err_cnt", i), err_cnt, vecs[i].exp_cnt);
    end
    idle(1);
    chk("drain.m_valid", m_valid, 0);
    chk("drain.m_par_held", m_par, 1);
    // mode sampled on first beat only
    send(1'b0, 8'h01, 1'b1, 1'b0);
    chk("t3.b1_valid", m_valid, 0);
    send(1'b1, 8'h03, 1'b0, 1'b0);
    send(1'b1, 8'h80, 1'b1, 1'b1);
    chk_out("t3", 1'b1, 1'b0, 1'b0);
    chk("t3.err_cnt", err_cnt, 2);
    // sticky frame error, then a clean frame
    s_valid = 1'b0; clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    chk("t4.clr", err_cnt, 0);
    send(1'b1, 8'h01, 1'b1, 1'b0);
    send(1'b1, 8'h07, 1'b0, 1'b1);
    chk_out("t4", 1'b1, 1'b1, 1'b1);
    chk("t4.err_cnt", err_cnt, 1);
    send(1'b0, 8'h00, 1'b0, 1'b1);
    chk_out("t4.clean", 1'b1, 1'b0, 1'b0);
    // back-pressure: result held, input stalled
    send(1'b1, 8'h0F, 1'b1, 1'b1);
    chk_out("t5.first", 1'b1, 1'b1, 1'b0);
    m_ready = 1'b0;
    odd_sel = 1'b1; s_data = 8'h01; s_par = 1'b0; s_last = 1'b1; s_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5.s_ready%0d", i), s_ready, 0);
      chk_out($sformatf("t5.hold%0d", i), 1'b1, 1'b1, 1'b0);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    #1;
    chk("t5.s_ready_rel", s_ready, 1);
    @(posedge clk); #1;
    chk_out("t5.next", 1'b1, 1'b0, 1'b0);
    idle(1);
    chk_out("t5.drain", 1'b0, 1'b0, 1'b0);
    // saturation on the 2-bit counter and clear priority
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 8'h01, 1'b0, 1'b1);
      chk($sformatf("t6.cnt2_%0d", i), err_cnt2, (i < 3) ? i + 1 : 3);
      chk($sformatf("t6.cnt8_%0d", i), err_cnt, i + 1);
      chk($sformatf("t6.err2_%0d", i), m_err2, 1);
    end
    clr_cnt = 1'b1;
    send(1'b0, 8'h01, 1'b0, 1'b1);
    clr_cnt = 1'b0;
    chk("t6.clr2", err_cnt2, 0);
    chk("t6.clr8", err_cnt, 0);
    idle(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
